controlador_rpn: RTL and testbench

Sequencer for the 4-deep RPN stack/ULA datapath. It converts pushbutton levels into the single-cycle entrada_numero, entrada_operacao and executar strobes that the stack expects. It tracks stack depth itself and blocks illegal pushes and executes. It holds the operation code stable for the ULA settle time before firing executar. It sits between the board I/O and the stack datapath.

---
 rtl/controlador_rpn.sv | 153 +++++++++++++++
 tb/tb_controlador_rpn.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/controlador_rpn.sv
// Turns button levels into single-cycle stack strobes and tracks depth/error state; push 2 cycles, op latch 1, execute LATENCIA_ULA+2 (edge cycle counted).
// No backpressure: button edges seen outside IDLE, and all but the highest-priority edge in IDLE, are dropped.
module controlador_rpn #(
    parameter int PROFUNDIDADE = 4,
    parameter int LATENCIA_ULA = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_numero,
    input  logic       btn_operacao,
    input  logic       btn_executar,
    input  logic [2:0] op_in,
    input  logic       limpar,
    output logic       entrada_numero,
    output logic       entrada_operacao,
    output logic       executar,
    output logic [2:0] operacao,
    output logic [2:0] profundidade,
    output logic       ocupado,
    output logic [1:0] erro_pilha,
    output logic [2:0] estado
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PUSH     = 3'd1,
        WAIT_ULA = 3'd2,
        EXEC     = 3'd3,
        ERRO     = 3'd4
    } estado_t;

    estado_t    state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] prof_q, prof_d;
    logic [1:0] erro_q, erro_d;
    logic [2:0] op_q, op_d;
    logic       op_valida_q, op_valida_d;
    logic       num_q, num_d, opr_q, opr_d, exe_q, exe_d;
    logic       ocupado_q, ocupado_d;
    logic       prev_num_q, prev_opr_q, prev_exe_q;
    logic       edge_num, edge_opr, edge_exe, go_exec;

    assign edge_num = btn_numero   & ~prev_num_q;
    assign edge_opr = btn_operacao & ~prev_opr_q;
    assign edge_exe = btn_executar & ~prev_exe_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prof_d      = prof_q;
        erro_d      = erro_q;
        op_d        = op_q;
        op_valida_d = op_valida_q;
        num_d       = 1'b0;
        opr_d       = 1'b0;
        exe_d       = 1'b0;
        go_exec     = 1'b0;
        case (state_q)
            IDLE: begin
                if (edge_num) begin
                    if (prof_q == 3'(PROFUNDIDADE)) begin
                        state_d = ERRO;
                        erro_d  = 2'b01;
                    end else begin
                        state_d = PUSH;
                        num_d   = 1'b1;
                        prof_d  = prof_q + 3'd1;
                    end
                end else if (edge_opr) begin
                    op_d        = op_in;
                    opr_d       = 1'b1;
                    op_valida_d = 1'b1;
                end else if (edge_exe) begin
                    if (!op_valida_q) begin
                        state_d = ERRO;
                        erro_d  = 2'b11;
                    end else if (prof_q < 3'd2) begin
                        state_d = ERRO;
                        erro_d  = 2'b10;
                    end else if (LATENCIA_ULA > 0) begin
                        state_d = WAIT_ULA;
                        cnt_d   = 8'd0;
                    end else begin
                        go_exec = 1'b1;
                    end
                end
            end
            PUSH: state_d = IDLE;
            WAIT_ULA: begin
                if (cnt_q == 8'(LATENCIA_ULA - 1)) go_exec = 1'b1;
                else cnt_d = cnt_q + 8'd1;
            end
            EXEC: state_d = IDLE;
            ERRO: begin
                if (limpar) begin
                    state_d = IDLE;
                    erro_d  = 2'b00;
                end
            end
            default: state_d = IDLE;
        endcase
        // Strobe and depth change are registered together so executar coincides with EXEC.
        if (go_exec) begin
            state_d     = EXEC;
            exe_d       = 1'b1;
            prof_d      = prof_q - 3'd1;
            op_valida_d = 1'b0;
        end
        ocupado_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            prof_q      <= 3'd0;
            erro_q      <= 2'b00;
            op_q        <= 3'd0;
            op_valida_q <= 1'b0;
            num_q       <= 1'b0;
            opr_q       <= 1'b0;
            exe_q       <= 1'b0;
            ocupado_q   <= 1'b0;
            prev_num_q  <= 1'b0;
            prev_opr_q  <= 1'b0;
            prev_exe_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prof_q      <= prof_d;
            erro_q      <= erro_d;
            op_q        <= op_d;
            op_valida_q <= op_valida_d;
            num_q       <= num_d;
            opr_q       <= opr_d;
            exe_q       <= exe_d;
            ocupado_q   <= ocupado_d;
            prev_num_q  <= btn_numero;
            prev_opr_q  <= btn_operacao;
            prev_exe_q  <= btn_executar;
        end
    end

    assign entrada_numero   = num_q;
    assign entrada_operacao = opr_q;
    assign executar         = exe_q;
    assign operacao         = op_q;
    assign profundidade     = prof_q;
    assign ocupado          = ocupado_q;
    assign erro_pilha       = erro_q;
    assign estado           = state_q;

endmodule

// File: tb/tb_controlador_rpn.sv
// Directed bench for controlador_rpn with LATENCIA_ULA=2.
module tb_controlador_rpn;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_numero = 1'b0, btn_operacao = 1'b0, btn_executar = 1'b0;
    logic [2:0] op_in = 3'd0;
    logic       limpar = 1'b0;
    logic       entrada_numero, entrada_operacao, executar, ocupado;
    logic [2:0] operacao, profundidade, estado;
    logic [1:0] erro_pilha;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_num = 0, n_opr = 0, n_exe = 0, n_occ = 0, n_viol = 0, exe_cyc = -1;

    controlador_rpn #(.PROFUNDIDADE(4), .LATENCIA_ULA(2)) dut (
        .clk(clk), .rst(rst),
        .btn_numero(btn_numero), .btn_operacao(btn_operacao), .btn_executar(btn_executar),
        .op_in(op_in), .limpar(limpar),
        .entrada_numero(entrada_numero), .entrada_operacao(entrada_operacao),
        .executar(executar), .operacao(operacao), .profundidade(profundidade),
        .ocupado(ocupado), .erro_pilha(erro_pilha), .estado(estado)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        n_num = n_num + int'(entrada_numero);
        n_opr = n_opr + int'(entrada_operacao);
        n_exe = n_exe + int'(executar);
        n_occ = n_occ + int'(ocupado);
        if (executar) exe_cyc = cyc;
        if (int'(entrada_numero) + int'(entrada_operacao) + int'(executar) > 1) n_viol = n_viol + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        btn_numero = 0; btn_operacao = 0; btn_executar = 0; limpar = 0;
        rst = 0;
        tick(2);
        rst = 1;
        tick(1);
    endtask

    task automatic push();
        btn_numero = 1; tick(1); btn_numero = 0; tick(2);
    endtask

    task automatic latch_op(input logic [2:0] op);
        op_in = op; btn_operacao = 1; tick(1); btn_operacao = 0; tick(2);
    endtask

    task automatic execute();
        btn_executar = 1; tick(1); btn_executar = 0; tick(6);
    endtask

    int s_num, s_opr, s_exe, s_occ, t0;

    initial begin
        // reset state
        rst = 0;
        tick(2);
        chk("rst_estado", estado, 0);
        chk("rst_strobes", {entrada_numero, entrada_operacao, executar}, 0);
        chk("rst_operacao", operacao, 0);
        chk("rst_prof", profundidade, 0);
        chk("rst_erro", erro_pilha, 0);
        chk("rst_ocupado", ocupado, 0);
        rst = 1;
        tick(1);

        // three pushes, each strobe exactly one cycle
        s_num = n_num;
        for (int i = 0; i < 3; i++) push();
        chk("push3_strobes", n_num - s_num, 3);
        chk("push3_prof", profundidade, 3);
        chk("push3_erro", erro_pilha, 0);

        // overflow on 5th push, then limpar
        do_reset();
        s_num = n_num;
        for (int i = 0; i < 5; i++) push();
        chk("ovf_strobes", n_num - s_num, 4);
        chk("ovf_estado", estado, 4);
        chk("ovf_erro", erro_pilha, 1);
        chk("ovf_prof", profundidade, 4);
        chk("ovf_ocupado", ocupado, 1);
        limpar = 1; tick(1); limpar = 0; tick(1);
        chk("clr_estado", estado, 0);
        chk("clr_erro", erro_pilha, 0);
        chk("clr_prof", profundidade, 4);

        // normal execute with ULA latency 2
        do_reset();
        push(); push();
        s_opr = n_opr;
        latch_op(3'b010);
        chk("op_strobes", n_opr - s_opr, 1);
        chk("op_val", operacao, 3'b010);
        chk("op_estado", estado, 0);
        s_exe = n_exe; s_occ = n_occ; t0 = cyc;
        execute();
        chk("exe_strobes", n_exe - s_exe, 1);
        // edge cycle counted as the first of LATENCIA_ULA+2
        chk("exe_latency", exe_cyc - t0 + 1, 4);
        chk("exe_ocupado_cycles", n_occ - s_occ, 3);
        chk("exe_prof", profundidade, 1);
        chk("exe_operacao_kept", operacao, 3'b010);
        chk("exe_estado", estado, 0);

        // underflow: depth 1 with valid op
        latch_op(3'b001);
        s_exe = n_exe;
        execute();
        chk("unf_estado", estado, 4);
        chk("unf_erro", erro_pilha, 2);
        chk("unf_no_exe", n_exe - s_exe, 0);

        // no operation latched
        do_reset();
        push(); push();
        s_exe = n_exe;
        execute();
        chk("noop_erro", erro_pilha, 3);
        chk("noop_no_exe", n_exe - s_exe, 0);

        // simultaneous numero and executar edges: numero wins
        do_reset();
        push(); push();
        latch_op(3'b010);
        s_num = n_num; s_exe = n_exe;
        btn_numero = 1; btn_executar = 1; tick(1);
        btn_numero = 0; btn_executar = 0; tick(6);
        chk("prio_num", n_num - s_num, 1);
        chk("prio_no_exe", n_exe - s_exe, 0);
        chk("prio_prof", profundidade, 3);

        // edges during WAIT_ULA are ignored
        s_num = n_num; s_opr = n_opr; s_exe = n_exe;
        btn_executar = 1; tick(1);
        chk("wait_estado", estado, 2);
        btn_executar = 0; btn_numero = 1; btn_operacao = 1; op_in = 3'b101; tick(1);
        btn_executar = 1; tick(1);
        btn_numero = 0; btn_operacao = 0; btn_executar = 0; tick(6);
        chk("wait_no_num", n_num - s_num, 0);
        chk("wait_no_opr", n_opr - s_opr, 0);
        chk("wait_one_exe", n_exe - s_exe, 1);
        chk("wait_prof", profundidade, 2);
        chk("wait_operacao", operacao, 3'b010);

        // async reset during WAIT_ULA, button held through release
        push();
        latch_op(3'b011);
        s_exe = n_exe;
        btn_executar = 1; tick(1); btn_executar = 0;
        chk("arst_in_wait", estado, 2);
        #2 rst = 0;
        btn_numero = 1;
        #1;
        chk("arst_estado", estado, 0);
        chk("arst_outputs", {entrada_numero, entrada_operacao, executar, operacao, profundidade, ocupado, erro_pilha}, 0);
        tick(2);
        s_num = n_num;
        rst = 1;
        tick(6);
        btn_numero = 0; tick(2);
        chk("arst_no_exe", n_exe - s_exe, 0);
        chk("arst_one_push", n_num - s_num, 1);
        chk("arst_prof", profundidade, 1);

        chk("strobe_exclusive", n_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
